// File: rtl/branch_resolve_queue_pkg.sv
// branch_resolve_queue_pkg: shared types and defaults for the branch predictor
// and its resolve queue.
package branch_resolve_queue_pkg;

    typedef enum logic [1:0] {
        ST_STRONG_NT = 2'b00,
        ST_WEAK_NT   = 2'b01,
        ST_WEAK_T    = 2'b10,
        ST_STRONG_T  = 2'b11
    } bp_state_e;

    localparam int BRQ_DEPTH = 4;
    localparam int BRQ_CNT_W = 16;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bpq_fifo.sv
// bpq_fifo: circular buffer of predicted directions with a separate occupancy
// count and a single-cycle flush that discards every entry.
module bpq_fifo
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_din,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic                   o_dout,
    output logic [ptr_w(DEPTH):0]  o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    // Flush collapses the write pointer onto the read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= r_rd_ptr;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: matches queued predictions against execute outcomes,
// trains the predictor, flushes wrong-path entries and keeps statistics.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int CNT_W = BRQ_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_pred_valid,
    input  logic                   i_pred_taken,
    input  logic                   i_res_valid,
    input  logic                   i_res_taken,
    input  logic                   i_clr_stats,
    output logic                   o_upd_valid,
    output logic                   o_upd_taken,
    output logic                   o_mispredict,
    output logic [ptr_w(DEPTH):0]  o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [CNT_W-1:0]       o_hit_cnt,
    output logic [CNT_W-1:0]       o_miss_cnt,
    output logic                   o_err_overflow,
    output logic                   o_err_underflow
);

    logic             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_res;
    logic             w_hit;
    logic             w_miss;
    logic             w_push;
    logic             w_ovf;
    logic             w_udf;
    logic             r_upd_valid;
    logic             r_upd_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             r_err_ovf;
    logic             r_err_udf;

    assign w_res  = i_res_valid && !w_empty;
    assign w_hit  = w_res && (w_head == i_res_taken);
    assign w_miss = w_res && !w_hit;
    // A hit frees the head slot this cycle; a miss makes any same-cycle push wrong-path.
    assign w_push = i_pred_valid && !w_miss && (!w_full || w_hit);
    assign w_ovf  = i_pred_valid && w_full && !w_res;
    assign w_udf  = i_res_valid && w_empty;

    bpq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (i_pred_taken),
        .i_pop   (w_hit),
        .i_flush (w_miss),
        .o_dout  (w_head),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid  <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
        end else begin
            r_upd_valid  <= w_res;
            r_upd_taken  <= w_res && i_res_taken;
            r_mispredict <= w_miss;
            r_hit_cnt    <= i_clr_stats ? '0 :
                            (w_hit && !(&r_hit_cnt)) ? r_hit_cnt + CNT_W'(1) : r_hit_cnt;
            r_miss_cnt   <= i_clr_stats ? '0 :
                            (w_miss && !(&r_miss_cnt)) ? r_miss_cnt + CNT_W'(1) : r_miss_cnt;
            r_err_ovf    <= !i_clr_stats && (r_err_ovf || w_ovf);
            r_err_udf    <= !i_clr_stats && (r_err_udf || w_udf);
        end
    end

    assign o_upd_valid     = r_upd_valid;
    assign o_upd_taken     = r_upd_taken;
    assign o_mispredict    = r_mispredict;
    assign o_full          = w_full;
    assign o_empty         = w_empty;
    assign o_hit_cnt       = r_hit_cnt;
    assign o_miss_cnt      = r_miss_cnt;
    assign o_err_overflow  = r_err_ovf;
    assign o_err_underflow = r_err_udf;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: table vectors, hand-written corner sequences and a
// queue-based reference model under random stimulus.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_pred_valid = 1'b0;
    logic             i_pred_taken = 1'b0;
    logic             i_res_valid = 1'b0;
    logic             i_res_taken = 1'b0;
    logic             i_clr_stats = 1'b0;
    logic             o_upd_valid;
    logic             o_upd_taken;
    logic             o_mispredict;
    logic [2:0]       o_count;
    logic             o_full;
    logic             o_empty;
    logic [CNT_W-1:0] o_hit_cnt;
    logic [CNT_W-1:0] o_miss_cnt;
    logic             o_err_overflow;
    logic             o_err_underflow;

    int checks = 0;
    int errors = 0;

    branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_pred_valid    (i_pred_valid),
        .i_pred_taken    (i_pred_taken),
        .i_res_valid     (i_res_valid),
        .i_res_taken     (i_res_taken),
        .i_clr_stats     (i_clr_stats),
        .o_upd_valid     (o_upd_valid),
        .o_upd_taken     (o_upd_taken),
        .o_mispredict    (o_mispredict),
        .o_count         (o_count),
        .o_full          (o_full),
        .o_empty         (o_empty),
        .o_hit_cnt       (o_hit_cnt),
        .o_miss_cnt      (o_miss_cnt),
        .o_err_overflow  (o_err_overflow),
        .o_err_underflow (o_err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pv, pt, rv, rt, clr;
        int c, uv, ut, mis, h, m, o, u;
    } vec_t;

    vec_t tv [24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int pv, input int pt, input int rv, input int rt, input int clr);
        i_pred_valid = 1'(pv);
        i_pred_taken = 1'(pt);
        i_res_valid  = 1'(rv);
        i_res_taken  = 1'(rt);
        i_clr_stats  = 1'(clr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int c, input int uv, input int ut,
                                input int mis, input int h, input int m, input int o, input int u);
        chk({tag, "_count"}, 32'(o_count), 32'(c));
        chk({tag, "_full"}, 32'(o_full), 32'(c == DEPTH));
        chk({tag, "_empty"}, 32'(o_empty), 32'(c == 0));
        chk({tag, "_upd_valid"}, 32'(o_upd_valid), 32'(uv));
        if (uv != 0) chk({tag, "_upd_taken"}, 32'(o_upd_taken), 32'(ut));
        chk({tag, "_mispredict"}, 32'(o_mispredict), 32'(mis));
        chk({tag, "_hit_cnt"}, 32'(o_hit_cnt), 32'(h));
        chk({tag, "_miss_cnt"}, 32'(o_miss_cnt), 32'(m));
        chk({tag, "_err_ovf"}, 32'(o_err_overflow), 32'(o));
        chk({tag, "_err_udf"}, 32'(o_err_underflow), 32'(u));
    endtask

    bit mq[$];
    int mh, mm, mo, mu;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //         pv pt rv rt clr  c uv ut mis h m o u
        tv[0]  = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0};
        tv[2]  = '{1, 1, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 0, 1, 1, 0,   2, 1, 1, 0, 1, 0, 0, 0};
        tv[4]  = '{0, 0, 1, 0, 0,   1, 1, 0, 0, 2, 0, 0, 0};
        tv[5]  = '{0, 0, 1, 1, 0,   0, 1, 1, 0, 3, 0, 0, 0};
        tv[6]  = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 3, 0, 0, 0};
        tv[7]  = '{1, 1, 0, 0, 0,   2, 0, 0, 0, 3, 0, 0, 0};
        tv[8]  = '{1, 0, 0, 0, 0,   3, 0, 0, 0, 3, 0, 0, 0};
        tv[9]  = '{0, 0, 1, 0, 0,   0, 1, 0, 1, 3, 1, 0, 0};
        tv[10] = '{0, 0, 1, 1, 0,   0, 0, 0, 0, 3, 1, 0, 1};
        tv[11] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0};
        tv[12] = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0};
        tv[13] = '{1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0};
        tv[14] = '{1, 1, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0};
        tv[15] = '{1, 1, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0};
        tv[16] = '{1, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 1, 0};
        tv[17] = '{0, 0, 0, 0, 1,   4, 0, 0, 0, 0, 0, 0, 0};
        tv[18] = '{1, 1, 1, 1, 0,   4, 1, 1, 0, 1, 0, 0, 0};
        tv[19] = '{0, 0, 1, 0, 0,   3, 1, 0, 0, 2, 0, 0, 0};
        tv[20] = '{0, 0, 1, 1, 0,   2, 1, 1, 0, 3, 0, 0, 0};
        tv[21] = '{1, 1, 1, 0, 0,   0, 1, 0, 1, 3, 1, 0, 0};
        tv[22] = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 3, 1, 0, 0};
        tv[23] = '{0, 0, 1, 1, 0,   0, 1, 1, 0, 4, 1, 0, 0};

        #12;
        expect_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tv[i].pv, tv[i].pt, tv[i].rv, tv[i].rt, tv[i].clr);
            tick();
            expect_state($sformatf("row%0d", i), tv[i].c, tv[i].uv, tv[i].ut, tv[i].mis,
                         tv[i].h, tv[i].m, tv[i].o, tv[i].u);
        end

        // Asynchronous reset with a resolve pending on the next edge.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0);
            tick();
        end
        expect_state("arst_fill", 3, 0, 0, 0, 4, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        tick();
        expect_state("arst_pulse", 2, 1, 1, 0, 5, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("arst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        tick();
        expect_state("arst_after", 0, 0, 0, 0, 0, 0, 0, 0);

        // Saturation of hit_cnt and clr_stats winning over a same-cycle hit.
        drive(0, 0, 1, 1, 0);
        tick();
        expect_state("sat_udf", 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 1, 1, 0);
            tick();
        end
        expect_state("sat_hold", 1, 1, 1, 0, SAT, 0, 0, 1);
        drive(1, 1, 1, 1, 1);
        tick();
        expect_state("sat_clr", 1, 1, 1, 0, 0, 0, 0, 0);

        // Random stimulus against a queue model.
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mq.delete();
        mh = 0; mm = 0; mo = 0; mu = 0;
        for (int n = 0; n < 400; n++) begin
            int pv, pt, rv, rt, clr, res, eu, et, emis;
            pv  = int'($urandom_range(0, 1));
            pt  = int'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 9) < 4) ? 1 : 0;
            rt  = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? int'(mq[0]) : int'($urandom_range(0, 1));
            clr = ($urandom_range(0, 29) == 0) ? 1 : 0;
            res = (rv != 0 && mq.size() > 0) ? 1 : 0;
            eu = res; et = rt; emis = 0;
            if (rv != 0 && res == 0) mu = 1;
            if (res != 0) begin
                if (int'(mq[0]) == rt) begin
                    if (mh < SAT) mh++;
                    void'(mq.pop_front());
                    if (pv != 0) mq.push_back(bit'(pt));
                end else begin
                    emis = 1;
                    if (mm < SAT) mm++;
                    mq.delete();
                end
            end else if (pv != 0) begin
                if (mq.size() < DEPTH) mq.push_back(bit'(pt));
                else mo = 1;
            end
            if (clr != 0) begin
                mh = 0; mm = 0; mo = 0; mu = 0;
            end
            drive(pv, pt, rv, rt, clr);
            tick();
            expect_state($sformatf("rnd%0d", n), mq.size(), eu, et, emis, mh, mm, mo, mu);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Downstream neighbour of the 2-bit saturating-counter branch predictor.
- Queues each prediction the predictor issues, in order, and matches it against the actual branch outcome from execute.
- Drives the predictor's training inputs (result/taken), flags mispredictions and flushes wrong-path entries.
- Keeps hit/miss statistics.

Parameters:
- DEPTH, 4: in-flight prediction slots; power of two, >= 2.
- CNT_W, 16: width of the hit/miss statistic counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_valid  in  1  predictor issued a prediction this cycle.
- pred_taken  in  1  predicted direction; predictor's prediction output.
- res_valid  in  1  execute resolved the oldest outstanding branch.
- res_taken  in  1  actual direction.
- clr_stats  in  1  synchronous clear of hit_cnt, miss_cnt and error flags.
- upd_valid  out  1  training strobe; drives predictor result.
- upd_taken  out  1  training direction; drives predictor taken.
- mispredict  out  1  one-cycle pulse, resolved direction != predicted.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- hit_cnt  out  CNT_W  correct predictions.
- miss_cnt  out  CNT_W  mispredictions.
- err_overflow  out  1  sticky; push attempted while full.
- err_underflow  out  1  sticky; resolve attempted while empty.

Behaviour:
- Reset (async, rst_n low):
  - Pointers, count, hit_cnt, miss_cnt = 0.
  - upd_valid, upd_taken, mispredict, err_* = 0.
  - empty = 1, full = 0.
  - Storage contents are don't-care.
- Storage: circular buffer of 1-bit predicted directions.
  - wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately so full and empty are unambiguous.
- Push: pred_valid && !full → store pred_taken at wr_ptr, wr_ptr+1, count+1.
- Push while full → entry dropped, err_overflow set, state otherwise unchanged.
- Resolve: res_valid && !empty → compare res_taken with entry at rd_ptr.
  - Next cycle (1-cycle registered latency): upd_valid=1, upd_taken=res_taken.
  - Match: hit_cnt+1, rd_ptr+1, count-1.
  - Mismatch: mispredict=1 next cycle, miss_cnt+1, and flush: all entries discarded (wr_ptr=rd_ptr, count=0), since younger predictions are wrong-path.
- Resolve while empty → no update strobe, no counter change, err_underflow set.
- Simultaneous push and resolve:
  - Resolve hit: both take effect; count unchanged. Full plus hit plus push is legal, because the pop frees the slot in the same cycle; no overflow.
  - Resolve miss: the same-cycle push is younger and is discarded; queue ends empty; no overflow flagged.
- Statistic counters saturate at all-ones; they never wrap.
- clr_stats: clears hit_cnt, miss_cnt, err_overflow, err_underflow in that cycle. It takes priority over a same-cycle increment; the queue is unaffected.
- upd_valid and mispredict are single-cycle pulses and are low in any cycle without a valid resolve on the previous edge.
- Reset asserted mid-operation: everything returns to reset values immediately; in-flight update pulses are dropped.

Decomposition:
- Shared package (branch predictor package), in place of literal values in RTL:
  - Counter state encodings: 2'b00 strong not-taken, 2'b01 weak not-taken, 2'b10 weak taken, 2'b11 strong taken.
  - Default DEPTH and CNT_W localparams.
  - A function returning pointer width from DEPTH.
- One natural sub-module: bpq_fifo, the circular buffer with pointers, count, full/empty and a flush input. The compare, statistics and error logic stay in the top.

Test Plan:
- Reset, then push taken, not-taken, taken (count=3); resolve taken, not-taken, taken → three upd_valid pulses with upd_taken 1,0,1; hit_cnt=3, miss_cnt=0, mispredict never high, empty=1 at end.
- Push 3 entries [1,1,0]; resolve first with res_taken=0 → mispredict pulse 1 cycle later, miss_cnt=1, count=0, empty=1; next resolve sets err_underflow.
- DEPTH=4: push 5 with no resolves → full=1 after the 4th, err_overflow=1 after the 5th, count=4. Then push and resolve-hit in the same cycle → count stays 4, err_overflow not re-triggered, wr_ptr/rd_ptr wrap to 1.
- With count=2, push and resolve-miss in the same cycle → count=0, pushed entry absent, mispredict=1.
- Force hit_cnt near saturation (CNT_W=4, 17 hits) → hit_cnt holds at 15. Assert clr_stats together with a hit → hit_cnt=0 and err flags cleared.
- With count=3 and a resolve in flight, drop rst_n asynchronously mid-cycle → outputs return to reset values before the next edge; no upd_valid pulse appears after release.
